// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access path.
package mem_pkg;

  localparam int DEPTH_DEF = 256;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/lane_align.sv
// Little-endian lane extraction (loads) and lane insertion (stores) for one 32-bit word.
module lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [4:0]  sh;
  logic [7:0]  bsel;
  logic [15:0] hsel;

  always_comb begin
    sh         = {lane, 3'b000};
    bsel       = 8'(word >> sh);
    hsel       = lane[1] ? word[31:16] : word[15:0];
    load_data  = '0;
    store_word = word;
    case (size)
      SZ_BYTE: begin
        load_data  = is_unsigned ? {24'h0, bsel} : {{24{bsel[7]}}, bsel};
        store_word = (word & ~(32'h0000_00ff << sh)) | ({24'h0, wdata[7:0]} << sh);
      end
      SZ_HALF: begin
        load_data  = is_unsigned ? {16'h0, hsel} : {{16{hsel[15]}}, hsel};
        store_word = lane[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      end
      SZ_WORD: begin
        load_data  = word;
        store_word = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store controller in front of the word-addressed DataMemory.
//   state | meaning
//   IDLE  | ready for a request; error check and latch on acceptance
//   RD    | MemRead asserted; rdata captured at the end of the cycle
//   WR    | MemWrite asserted for one cycle
//   RESP  | response formed; resp_valid pulses in the following cycle
module load_store_unit
  import mem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] adress,
  output logic [31:0] wdata,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] rdata
);

  lsu_state_t  state;
  logic        wr_q, uns_q, err_q;
  logic [1:0]  size_q, lane_q;
  logic [31:0] wdata_q, word_q;
  logic [31:0] align_word, load_data, store_word;
  logic        acc_err;

  assign req_ready = (state == IDLE) && rst_n;

  assign acc_err = (req_size == 2'b11)
                || ((req_size == SZ_HALF) && req_addr[0])
                || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                || ({2'b00, req_addr[31:2]} >= 32'(DEPTH));

  // Merge needs the word arriving from memory during RD; extraction uses the captured copy.
  assign align_word = (state == RD) ? rdata : word_q;

  lane_align u_lane_align (
    .word        (align_word),
    .wdata       (wdata_q),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .load_data   (load_data),
    .store_word  (store_word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
      MemWrite   <= 1'b0;
      MemRead    <= 1'b0;
      adress     <= '0;
      wdata      <= '0;
      wr_q       <= 1'b0;
      uns_q      <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= SZ_BYTE;
      lane_q     <= 2'b00;
      wdata_q    <= '0;
      word_q     <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          wr_q    <= req_write;
          uns_q   <= req_unsigned;
          err_q   <= acc_err;
          size_q  <= req_size;
          lane_q  <= req_addr[1:0];
          wdata_q <= req_wdata;
          adress  <= {{(32-AW){1'b0}}, req_addr[AW+1:2]};
          if (acc_err) begin
            state <= RESP;
          end else if (req_write && (req_size == SZ_WORD)) begin
            state    <= WR;
            MemWrite <= 1'b1;
            wdata    <= req_wdata;
          end else begin
            state   <= RD;
            MemRead <= 1'b1;
          end
        end
        RD: begin
          word_q <= rdata;
          if (wr_q) begin
            state    <= WR;
            MemWrite <= 1'b1;
            wdata    <= store_word;
          end else begin
            state <= RESP;
          end
        end
        WR: state <= RESP;
        RESP: begin
          resp_valid <= 1'b1;
          resp_error <= err_q;
          resp_rdata <= (err_q || wr_q) ? 32'h0 : load_data;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed checks of load_store_unit against a word-array reference model.
module tb_load_store_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] adress;
  logic [31:0] wdata;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] rdata;

  logic [31:0] dmem    [0:255] = '{default: 32'h0};
  logic [31:0] ref_mem [0:255] = '{default: 32'h0};

  int n_chk = 0, n_bad = 0;
  int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, hs_cnt = 0;
  logic [31:0] last_wa = '0, last_wd = '0;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .adress(adress), .wdata(wdata),
    .MemWrite(MemWrite), .MemRead(MemRead), .rdata(rdata)
  );

  always #5 clk = ~clk;

  assign rdata = dmem[adress[7:0]];
  always @(posedge clk) if (MemWrite) dmem[adress[7:0]] <= wdata;

  always @(posedge clk) if (req_valid && req_ready) hs_cnt++;

  always @(negedge clk) begin
    if (MemRead) rd_cnt++;
    if (MemWrite) begin
      wr_cnt++;
      last_wa = adress;
      last_wd = wdata;
    end
    if (MemRead && MemWrite) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
        || (a / 4 >= 256);
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input bit uns, input logic [31:0] a);
    logic [31:0] w, v;
    int sh;
    w  = ref_mem[a[9:2]];
    sh = 8 * int'(a % 4);
    v  = w;
    if (sz == 2'd0) begin
      v = (w >> sh) & 32'hFF;
      if (!uns && v >= 128) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> sh) & 32'hFFFF;
      if (!uns && v >= 32768) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w, mask;
    int sh;
    w  = ref_mem[a[9:2]];
    sh = 8 * int'(a % 4);
    if (sz == 2'd2) return d;
    mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic run_req(input bit w, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] d, output logic [31:0] got);
    bit e;
    logic [31:0] exp_rd, new_w;
    logic [7:0] wi;
    int exp_lat, lat, t, rd0, wr0, hs0;
    e       = m_err(sz, a);
    wi      = a[9:2];
    exp_rd  = (e || w) ? 32'h0 : m_load(sz, uns, a);
    new_w   = (!e && w) ? m_store(sz, a, d) : 32'h0;
    exp_lat = e ? 1 : ((w && sz != 2'd2) ? 3 : 2);
    got     = '0;
    @(negedge clk);
    rd0 = rd_cnt; wr0 = wr_cnt; hs0 = hs_cnt;
    req_write = w; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    if (t >= 20) begin
      chk("ready_timeout", 32'h0, 32'h1);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 8) begin @(negedge clk); lat++; end
    got = resp_rdata;
    chk("latency", lat, exp_lat);
    chk("resp_error", {31'h0, resp_error}, {31'h0, e});
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("mem_reads", rd_cnt - rd0, (!e && (!w || sz != 2'd2)) ? 1 : 0);
    chk("mem_writes", wr_cnt - wr0, (!e && w) ? 1 : 0);
    chk("accepts", hs_cnt - hs0, 1);
    if (!e && w) begin
      chk("wr_adress", last_wa, {24'h0, wi});
      chk("wr_wdata", last_wd, new_w);
      ref_mem[wi] = new_w;
      chk("dmem_word", dmem[wi], new_w);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] b2b_exp [3];
    logic [31:0] b2b_addr [3];
    logic [1:0]  b2b_sz [3];
    bit          b2b_uns [3];
    int wsnap, t;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h0);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_error", {31'h0, resp_error}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_strobes", {30'h0, MemRead, MemWrite}, 32'h0);
    chk("rst_adress", adress, 32'h0);
    chk("rst_wdata", wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'h0, req_ready}, 32'h1);

    run_req(1, SZ_WORD, 0, 32'h04, 32'h8, rd);
    run_req(0, SZ_WORD, 0, 32'h04, 32'h0, rd);
    chk("lw_4", rd, 32'h8);
    run_req(1, SZ_WORD, 0, 32'h1C, 32'h1122_3344, rd);
    run_req(1, SZ_BYTE, 0, 32'h1D, 32'hAB, rd);
    chk("sb_merge", dmem[7], 32'h1122_AB44);
    run_req(0, SZ_BYTE, 1, 32'h1D, 32'h0, rd);
    chk("lbu_1d", rd, 32'h0000_00AB);
    run_req(0, SZ_BYTE, 0, 32'h1D, 32'h0, rd);
    chk("lb_1d", rd, 32'hFFFF_FFAB);
    run_req(1, SZ_WORD, 0, 32'h3C, 32'h8000_7FFF, rd);
    run_req(0, SZ_HALF, 0, 32'h3E, 32'h0, rd);
    chk("lh_3e", rd, 32'hFFFF_8000);
    run_req(0, SZ_HALF, 1, 32'h3C, 32'h0, rd);
    chk("lhu_3c", rd, 32'h0000_7FFF);
    run_req(0, SZ_WORD, 0, 32'h06, 32'h0, rd);
    run_req(0, SZ_HALF, 0, 32'h01, 32'h0, rd);
    run_req(1, SZ_WORD, 0, 32'h400, 32'hDEAD_BEEF, rd);
    run_req(0, 2'b11, 0, 32'h00, 32'h0, rd);

    // reset during the RD cycle of a byte store
    run_req(1, SZ_WORD, 0, 32'h50, 32'hCAFE_F00D, rd);
    @(negedge clk);
    req_write = 1'b1; req_size = SZ_BYTE; req_addr = 32'h51; req_wdata = 32'h77;
    req_valid = 1'b1;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    @(negedge clk);
    req_valid = 1'b0;
    chk("rmw_in_rd", {31'h0, MemRead}, 32'h1);
    wsnap = wr_cnt;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_ready", {31'h0, req_ready}, 32'h0);
    chk("midrst_read", {31'h0, MemRead}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_nowrite", wr_cnt - wsnap, 32'h0);
    chk("midrst_mem", dmem[20], 32'hCAFE_F00D);
    chk("midrst_ready_after", {31'h0, req_ready}, 32'h1);
    run_req(0, SZ_WORD, 0, 32'h50, 32'h0, rd);
    chk("midrst_reload", rd, 32'hCAFE_F00D);

    // back-to-back loads with req_valid held high
    b2b_addr[0] = 32'h04; b2b_sz[0] = SZ_WORD; b2b_uns[0] = 0;
    b2b_addr[1] = 32'h1D; b2b_sz[1] = SZ_BYTE; b2b_uns[1] = 1;
    b2b_addr[2] = 32'h3E; b2b_sz[2] = SZ_HALF; b2b_uns[2] = 0;
    for (int i = 0; i < 3; i++) b2b_exp[i] = m_load(b2b_sz[i], b2b_uns[i], b2b_addr[i]);
    wsnap = hs_cnt;
    fork
      begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          req_write = 1'b0; req_size = b2b_sz[i]; req_unsigned = b2b_uns[i];
          req_addr = b2b_addr[i]; req_valid = 1'b1;
          for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
          @(negedge clk);
        end
        req_valid = 1'b0;
      end
      begin
        int n, tt;
        n = 0; tt = 0;
        while (n < 3 && tt < 80) begin
          @(negedge clk);
          tt++;
          if (resp_valid) begin
            chk("b2b_rdata", resp_rdata, b2b_exp[n]);
            n++;
          end
        end
        chk("b2b_resp_count", n, 3);
      end
    join
    repeat (3) @(negedge clk);
    chk("b2b_accepts", hs_cnt - wsnap, 3);

    for (int i = 0; i < 60; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 8) * 32'h400);
      run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, rd);
    end

    chk("rw_exclusive", both_cnt, 32'h0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side access controller for the single-cycle MIPS data memory. It accepts byte, halfword and word load/store requests from the datapath over a valid/ready handshake and drives the word-addressed DataMemory port (`adress`, `wdata`, `MemWrite`, `MemRead`, `rdata`). It performs read-modify-write for sub-word stores, sign- or zero-extends loads, and flags misaligned or out-of-range accesses. It replaces direct datapath wiring to DataMemory so the core can add `lb`/`lbu`/`lh`/`lhu`/`sb`/`sh`.

## Interface
Parameters:
- `DEPTH`, default 256: number of 32-bit words in DataMemory.
- `AW`, default `$clog2(DEPTH)` = 8: word-index width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block accepts a request this cycle.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_error` out 1: valid with `resp_valid`; access was rejected.
- `adress` out 32: word index to DataMemory, equal to `{0, req_addr[AW+1:2]}`.
- `wdata` out 32: full word to write.
- `MemWrite` out 1: write strobe.
- `MemRead` out 1: read enable.
- `rdata` in 32: DataMemory read data.

## Operation
- FSM states: IDLE, RD, WR, RESP. The request fields are latched on acceptance (`req_valid && req_ready`).
- `req_ready` = (state == IDLE) && `rst_n`.
- Error check at acceptance; an error goes IDLE→RESP with no memory strobe. Any one of the following is an error:
  - `req_size` = 11
  - half with `addr[0]` ≠ 0
  - word with `addr[1:0]` ≠ 0
  - `addr[31:2]` ≥ `DEPTH`
- Transitions:
  - Load: IDLE→RD→RESP.
  - Word store: IDLE→WR→RESP.
  - Byte/half store: IDLE→RD→WR→RESP.
- RD cycle: `MemRead` = 1 and `adress` is valid. `rdata` is captured into the word register at the end of RD.
- WR cycle: `MemWrite` = 1 for exactly one cycle.
  - Word store: `wdata` = `req_wdata`.
  - Sub-word store: `wdata` = captured word with the target lane replaced.
- Byte lanes are little-endian:
  - Byte lane `addr[1:0]`: k maps to bits [8k+7:8k].
  - Half lane `addr[1]`: 0 = [15:0], 1 = [31:16].
- Load extraction: select the lane, then extend per `req_unsigned`. Word loads ignore `req_unsigned`.
- RESP: `resp_valid` = 1 for one cycle, then IDLE. There is no response backpressure.
- `MemRead` and `MemWrite` are never high together. Both are 0 in IDLE and RESP.

## Timing
- Reset values (the edge with `rst_n` = 0):
  - state = IDLE
  - `resp_valid` = 0, `resp_error` = 0, `resp_rdata` = 0
  - `MemWrite` = 0, `MemRead` = 0
  - `adress` = 0, `wdata` = 0
  - `req_ready` = 0 while `rst_n` = 0
- Accept at edge E0. `resp_valid` is high in the cycle after:
  - E1 for an error.
  - E2 for a load or a word store.
  - E3 for a sub-word store.
- Throughput: one request per 2–4 cycles. The next acceptance is possible in the cycle after RESP.
- `req_valid` high while `req_ready` = 0 is ignored. The request holder keeps its request asserted until it is accepted.
- Reset mid-operation: return to IDLE at that edge. No write is issued afterwards. A pending RMW is abandoned and memory is untouched unless WR had already completed.
- `rdata` must be valid by the end of the RD cycle, which is the combinational DataMemory read path.

## Structure
- Shared package `mem_pkg`:
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`
  - FSM state enum
  - `DEPTH` default
- One sub-module, `lane_align`, purely combinational:
  - `extract(word, addr[1:0], size, unsigned)` → load data.
  - `merge(word, wdata, addr[1:0], size)` → store word.
- The top level holds the FSM, the latched request, and the captured-word register.

## Test plan
- Word store addr 0x04, data 0x00000008, then word load 0x04 → one `MemWrite` with `adress` = 1 and `wdata` = 8; the load returns `resp_rdata` = 0x00000008 two cycles after acceptance, `resp_error` = 0.
- Preload word 7 = 0x11223344; `sb` addr 0x1D data 0xAB → RD then WR with `wdata` = 0x1122AB44; a following `lbu` 0x1D returns 0x000000AB and `lb` 0x1D returns 0xFFFFFFAB.
- Preload word 15 = 0x8000_7FFF; `lh` 0x3E → 0xFFFF8000; `lhu` 0x3C → 0x00007FFF.
- Errors, each giving a `resp_valid` pulse one cycle after acceptance with `resp_error` = 1 and no `MemRead`/`MemWrite`:
  - `lw` 0x06 (misaligned)
  - `lh` 0x01 (misaligned)
  - `sw` 0x400 (word 256 ≥ `DEPTH`)
  - size 11
- Reset asserted during the RD cycle of an `sb` → no `MemWrite` ever asserts and the memory word is unchanged; after release, `req_ready` = 1 and the next request completes normally.
- Back-to-back: `req_valid` held high with three queued requests → `req_ready` is only high in IDLE, each request is accepted exactly once, and responses arrive in order.
